// File: rtl/alu_mac_pkg.sv
// alu_mac_pkg: shared definitions for the ALU multiply/MAC stage.
//   - FSM state encodings (IDLE, RUN, DONE)
//   - job mode encodings (MULT, MAC)
//   - round_sat(): round-half-up by F fractional bits, then saturate to W bits
package alu_mac_pkg;

   // FSM state encoding
   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   // Job mode encoding, captured at start
   localparam logic ModeMult = 1'b0;
   localparam logic ModeMac  = 1'b1;

   // Working width of round_sat; callers sign-extend into it and slice the result.
   localparam int unsigned RsWidth = 64;

   typedef struct packed {
      logic [RsWidth-1:0] res;
      logic               sat;
   } rs_t;

   // r = (v + 2^(f-1)) >>> f, clamped to the signed w-bit range.
   function automatic rs_t round_sat(input logic signed [RsWidth-1:0] v,
                                     input int unsigned w,
                                     input int unsigned f);
      logic signed [RsWidth-1:0] r;
      logic signed [RsWidth-1:0] hi;
      logic signed [RsWidth-1:0] lo;
      rs_t o;
      r  = (v + (64'sd1 <<< (f - 1))) >>> f;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      o.res = r;
      o.sat = 1'b0;
      if (r > hi) begin
         o.res = hi;
         o.sat = 1'b1;
      end else if (r < lo) begin
         o.res = lo;
         o.sat = 1'b1;
      end
      return o;
   endfunction

endpackage

// File: rtl/sfixed_mult_lane.sv
// sfixed_mult_lane: one signed fixed-point multiply lane.
// Ports:
//   clk, rst      clock, async active-high reset
//   snap          capture x/y into the job snapshot
//   x, y          operand register values
//   mac           job mode is MAC (held stable for the whole job)
//   done          result-capture edge of the job
//   acc_clr       synchronous accumulator clear
//   result        rounded/saturated lane result, held between jobs
//   sat_flag      last job's result was saturated
module sfixed_mult_lane
   import alu_mac_pkg::*;
#(
   parameter int unsigned BUS_WIDTH  = 8,
   parameter int unsigned FRAC_BITS  = 7,
   parameter int unsigned PIPE_DEPTH = 2,
   parameter int unsigned ACC_GUARD  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 snap,
   input  logic [BUS_WIDTH-1:0] x,
   input  logic [BUS_WIDTH-1:0] y,
   input  logic                 mac,
   input  logic                 done,
   input  logic                 acc_clr,
   output logic [BUS_WIDTH-1:0] result,
   output logic                 sat_flag
);

   localparam int unsigned PW = 2 * BUS_WIDTH;
   localparam int unsigned AW = PW + ACC_GUARD;

   logic [BUS_WIDTH-1:0]   xs_q, ys_q;
   logic signed [PW-1:0]   prod;
   logic signed [PW-1:0]   prod_last;
   logic signed [AW-1:0]   acc_q, acc_d;
   logic signed [RsWidth-1:0] v;
   rs_t                    rs;
   logic [BUS_WIDTH-1:0]   result_q;
   logic                   sat_q;
   logic                   unused_hi;

   // Job snapshot: later operand loads do not disturb the job in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xs_q <= '0;
         ys_q <= '0;
      end else if (snap) begin
         xs_q <= x;
         ys_q <= y;
      end
   end

   assign prod = PW'($signed(xs_q)) * PW'($signed(ys_q));

   // Free-running product pipeline; the snapshot is stable for the whole job, so the
   // last stage holds this job's product by the result-capture edge.
   if (PIPE_DEPTH == 1) begin : g_no_pipe
      assign prod_last = prod;
   end else begin : g_pipe
      logic signed [PW-1:0] pipe_q [PIPE_DEPTH-1];
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int i = 0; i < int'(PIPE_DEPTH) - 1; i++) pipe_q[i] <= '0;
         end else begin
            pipe_q[0] <= prod;
            for (int i = 1; i < int'(PIPE_DEPTH) - 1; i++) pipe_q[i] <= pipe_q[i-1];
         end
      end
      assign prod_last = pipe_q[PIPE_DEPTH-2];
   end

   // Clear wins over accumulate but still folds in the current product.
   always_comb begin
      acc_d = acc_q;
      if (done && mac) begin
         acc_d = acc_clr ? AW'(prod_last) : acc_q + AW'(prod_last);
      end else if (acc_clr) begin
         acc_d = '0;
      end
   end

   always_comb begin
      v  = mac ? RsWidth'(acc_d) : RsWidth'(prod_last);
      rs = round_sat(v, BUS_WIDTH, FRAC_BITS);
   end

   assign unused_hi = ^rs.res[RsWidth-1:BUS_WIDTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q    <= '0;
         result_q <= '0;
         sat_q    <= 1'b0;
      end else begin
         acc_q <= acc_d;
         if (done) begin
            result_q <= rs.res[BUS_WIDTH-1:0];
            sat_q    <= rs.sat;
         end
      end
   end

   assign result   = result_q;
   assign sat_flag = sat_q;

endmodule

// File: rtl/alu_mac_stage.sv
// alu_mac_stage: LANES parallel signed fixed-point multiply/MAC lanes sharing one
// coefficient bus, with a start/busy/out_valid job handshake.
// Ports:
//   clk, rst    clock, async active-high reset
//   x_en        per-lane load of data_in slice into X
//   y_en        per-lane load of coeff into Y
//   data_in     lane i data at [i*W +: W]
//   coeff       shared coefficient
//   start       launch a job (ignored while busy)
//   mode        0 = MULT, 1 = MAC, captured at start
//   acc_clr     synchronous clear of all accumulators
//   busy        job in flight
//   out_valid   one-cycle pulse when result/sat_flag update
//   result      lane results, held between jobs
//   sat_flag    per-lane saturation of the last job
module alu_mac_stage
   import alu_mac_pkg::*;
#(
   parameter int unsigned BUS_WIDTH  = 8,
   parameter int unsigned FRAC_BITS  = 7,
   parameter int unsigned LANES      = 2,
   parameter int unsigned PIPE_DEPTH = 2,
   parameter int unsigned ACC_GUARD  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [LANES-1:0]           x_en,
   input  logic [LANES-1:0]           y_en,
   input  logic [LANES*BUS_WIDTH-1:0] data_in,
   input  logic [BUS_WIDTH-1:0]       coeff,
   input  logic                       start,
   input  logic                       mode,
   input  logic                       acc_clr,
   output logic                       busy,
   output logic                       out_valid,
   output logic [LANES*BUS_WIDTH-1:0] result,
   output logic [LANES-1:0]           sat_flag
);

   localparam int unsigned CntW = $clog2(PIPE_DEPTH) + 1;

   logic [BUS_WIDTH-1:0] x_q [LANES];
   logic [BUS_WIDTH-1:0] y_q [LANES];
   logic [1:0]           state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic                 mode_q, mode_d;
   logic                 snap, done;

   // Operand registers load at any time, including mid-job.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(LANES); i++) begin
            x_q[i] <= '0;
            y_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(LANES); i++) begin
            if (x_en[i]) x_q[i] <= data_in[i*BUS_WIDTH +: BUS_WIDTH];
            if (y_en[i]) y_q[i] <= coeff;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               cnt_d   = CntW'(PIPE_DEPTH - 1);
               mode_d  = mode;
            end
         end
         StRun: begin
            if (cnt_q == '0) state_d = StDone;
            else             cnt_d   = cnt_q - CntW'(1);
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         mode_q  <= ModeMult;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
      end
   end

   assign snap      = (state_q == StIdle) && start;
   // Edge that enters DONE: lanes register results and accumulate here.
   assign done      = (state_q == StRun) && (cnt_q == '0);
   assign busy      = (state_q != StIdle);
   assign out_valid = (state_q == StDone);

   for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
      sfixed_mult_lane #(
         .BUS_WIDTH (BUS_WIDTH),
         .FRAC_BITS (FRAC_BITS),
         .PIPE_DEPTH(PIPE_DEPTH),
         .ACC_GUARD (ACC_GUARD)
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .snap    (snap),
         .x       (x_q[i]),
         .y       (y_q[i]),
         .mac     (mode_q == ModeMac),
         .done    (done),
         .acc_clr (acc_clr),
         .result  (result[i*BUS_WIDTH +: BUS_WIDTH]),
         .sat_flag(sat_flag[i])
      );
   end

endmodule

// File: doc/alu_mac_stage.md
Name: alu_mac_stage

Overview:
Next-generation ALU multiply stage: LANES parallel signed fixed-point multiply lanes sharing one coefficient bus.
- Adds per-job operand snapshot, a PIPE_DEPTH-stage multiplier pipeline with a start/busy/valid handshake, round-half-up, saturation with flags, and a per-lane MAC accumulate mode.
- Sits between the register-file read ports and the ALU result mux.

Parameters:
- BUS_WIDTH, 8, operand/result width W in bits, signed two's complement.
- FRAC_BITS, 7, fractional bits F of operands and results (Q(W-F-1).F). Range 1..W-1.
- LANES, 2, number of independent multiply lanes. Range 1..8.
- PIPE_DEPTH, 2, multiplier register stages after operand snapshot. Range 1..4.
- ACC_GUARD, 4, extra integer guard bits in each MAC accumulator.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- x_en  in  LANES  per-lane load of data_in slice into X operand register.
- y_en  in  LANES  per-lane load of coeff into Y operand register.
- data_in  in  LANES*W  lane i data at bits [i*W +: W].
- coeff  in  W  shared coefficient.
- start  in  1  launch job; sampled only when busy=0.
- mode  in  1  0 = MULT, 1 = MAC; captured at start.
- acc_clr  in  1  synchronous clear of all accumulators.
- busy  out  1  job in flight.
- out_valid  out  1  one-cycle pulse, results updated.
- result  out  LANES*W  lane results, held between jobs.
- sat_flag  out  LANES  lane i result was saturated in the last job.

Behaviour:
- Reset: all X/Y registers, pipeline, accumulators, result, sat_flag = 0; busy = 0, out_valid = 0; FSM = IDLE.
- Reset asserted mid-job aborts the job; no out_valid is produced.
- Operand regs: on each edge, X[i] <= data_in slice if x_en[i]; Y[i] <= coeff if y_en[i]. Loads are legal at any time, including while busy.
- FSM states IDLE, RUN, DONE:
  - IDLE: start=1 at edge k snapshots all X/Y and mode into stage 0, loads cnt = PIPE_DEPTH-1, goes to RUN; busy=1 from k.
  - RUN: cnt decrements each edge; at cnt=0 goes to DONE.
  - DONE: result/sat_flag registered and out_valid=1 for exactly one cycle, in the cycle after edge k+PIPE_DEPTH. busy is still 1 in that cycle. Next edge returns to IDLE, busy=0.
  - start while busy=1 is ignored, not queued. Back-to-back jobs are therefore PIPE_DEPTH+2 cycles apart.
- Operand loads after edge k do not affect the in-flight job.
- Arithmetic per lane:
  - p = X*Y, full 2W signed.
  - MULT: v = p.
  - MAC: acc <= acc + p, with acc of width 2W+ACC_GUARD and wrap on acc overflow; v = new acc. The acc update happens at the DONE edge.
  - Rounding: r = (v + 2^(F-1)) >>> F (arithmetic shift, round-half-up).
  - Saturation: if r > 2^(W-1)-1, result = 0x7F..F and sat_flag=1; if r < -2^(W-1), result = 0x80..0 and sat_flag=1; else result = r[W-1:0] and sat_flag=0.
- acc_clr: clears accumulators at the edge. If coincident with the DONE accumulate edge, clear takes priority and acc <= p, i.e. a fresh start including the current product. acc_clr in IDLE/RUN simply zeroes.
- MULT jobs never modify accumulators.

Decomposition:
- Package alu_mac_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the mode encoding constants;
  - a function round_sat(v, W, F) returning result and sat flag.
- Sub-module sfixed_mult_lane: one lane holding the product pipeline of PIPE_DEPTH stages plus accumulator, instantiated LANES times via generate.
- The FSM and counter live in the top module.

Test Plan (all at W=8, F=7, LANES=2, PIPE_DEPTH=2 unless noted):
- MULT basic: X0=0x40, Y0=0x40, X1=0xC0, Y1=0x40, start → out_valid exactly 3 cycles after the start edge; result0=0x20, result1=0xE0, sat_flag=00.
- Saturation and rounding: X0=Y0=0x80 gives result0=0x7F, sat_flag[0]=1. X1=0x01, Y1=0x40 gives p=64, which rounds to result1=0x01.
- MAC: acc_clr, then three MAC jobs with 0x40*0x40 → results 0x20, 0x40, 0x60. A fourth job with acc_clr on its DONE edge → 0x20.
- Busy/isolation: start pulsed again in every cycle while busy and operands reloaded during RUN → only one out_valid; results reflect the snapshot values; the next start is accepted only after busy falls.
- Reset mid-job: assert rst in the RUN state → all outputs are 0 immediately (async), no out_valid follows, and the next job behaves normally.
- Parameter sweep: PIPE_DEPTH=1 and 4, LANES=1 and 4 with a random operand model → latency of PIPE_DEPTH+1 cycles and bit-exact match to round_sat.
